// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and constants for the enable/data feeder
package feeder_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int RESET_VALUE_DEFAULT = 42;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry skid storage with occupancy state machine
module skid_fifo2
  import feeder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output occ_e             occupancy
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  occ_e             occ_q;
  occ_e             occ_d;

  assign head_data = mem[rd_ptr];
  assign occupancy = occ_q;

  // Pointers reset; the storage words do not, their contents are simply ignored while empty.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Occupancy state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Occupancy next state: push alone grows, pop alone shrinks, both together hold.
  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      EMPTY: if (push && !pop) occ_d = ONE;
      ONE: begin
        if (push && !pop)      occ_d = TWO;
        else if (pop && !push) occ_d = EMPTY;
      end
      TWO:   if (pop && !push) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

endmodule

// File: rtl/enable_skid_feeder.sv
// rtl/enable_skid_feeder.sv - valid/ready stream to registered enable/data pair
module enable_skid_feeder
  import feeder_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int RESET_VALUE = RESET_VALUE_DEFAULT,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 stall,
  output logic                 out_enable,
  output logic [WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  occ_e             occupancy;
  logic [WIDTH-1:0] head_data;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             fifo_push;

  // Ready depends only on the occupancy flop and reset, never on stall or in_valid.
  assign in_ready  = !reset && (occupancy != TWO);
  assign push      = in_valid && in_ready;
  assign pop       = !stall && (occupancy != EMPTY);
  assign bypass    = push && !stall && (occupancy == EMPTY);
  assign fifo_push = push && !bypass;

  skid_fifo2 #(
    .WIDTH(WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_data),
    .occupancy (occupancy)
  );

  // Output register: emit the buffered head first, else forward the incoming word, else hold data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_enable <= 1'b0;
      out_data   <= WIDTH'(RESET_VALUE);
      xfer_count <= '0;
    end else if (pop) begin
      out_enable <= 1'b1;
      out_data   <= head_data;
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end else if (bypass) begin
      out_enable <= 1'b1;
      out_data   <= in_data;
      xfer_count <= xfer_count + CNT_WIDTH'(1);
    end else begin
      out_enable <= 1'b0;
    end
  end

endmodule
